// File: rtl/chan_frame_pkg.sv
// rtl/chan_frame_pkg.sv - shared types and helpers for the channel frame packer
package chan_frame_pkg;

  localparam int CHAN_NUM = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
    ST_SUM
  } state_t;

  // Header word: tag in the upper byte, channel number in the low bits.
  function automatic logic [15:0] build_hdr(input logic [7:0] tag, input logic [1:0] chan);
    return {tag, 6'd0, chan};
  endfunction

  // Channel reached by stepping k places after last, wrapping over CHAN_NUM.
  function automatic logic [1:0] rr_chan(input logic [1:0] last, input int k);
    int v;
    v = (int'(last) + k) % CHAN_NUM;
    return v[1:0];
  endfunction

endpackage

// File: rtl/chan_buf.sv
// rtl/chan_buf.sv - per-channel ring buffer with occupancy count
module chan_buf #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [15:0]   wdata,
  input  logic          rd,
  output logic [15:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A write into a full buffer still lands when a pop frees a slot on the same edge.
  assign w_pop  = rd && (r_count != '0);
  assign w_push = wr && ((r_count != CW'(DEPTH)) || w_pop);
  assign rdata  = r_mem[r_rptr];
  assign count  = r_count;
  assign full   = (r_count == CW'(DEPTH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; contents need no reset because the count gates validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/chan_frame_pack.sv
// rtl/chan_frame_pack.sv - repackages a channel-tagged word stream into framed packets
module chan_frame_pack
  import chan_frame_pkg::*;
#(
  parameter int         FRAME_LEN = 4,
  parameter logic [7:0] HDR_TAG   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic [1:0]  din_chan,
  output logic [15:0] dout,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic [1:0]  dout_chan,
  output logic [2:0]  ovf,
  output logic        bad_chan
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_chan;
  logic [1:0]          r_last;
  logic [1:0]          w_pick;
  logic                w_any_rdy;
  logic                w_xfer;
  logic [BW-1:0]       r_beat;
  logic [15:0]         r_sum;
  logic [15:0]         w_head;
  logic [CHAN_NUM-1:0] w_wr;
  logic [CHAN_NUM-1:0] w_rd;
  logic [CHAN_NUM-1:0] w_full;
  logic [CHAN_NUM-1:0] w_rdy;
  logic [CHAN_NUM-1:0] w_drop;
  logic [CW-1:0]       w_count [CHAN_NUM];
  logic [15:0]         w_rdata [CHAN_NUM];
  logic [CHAN_NUM-1:0] r_ovf;
  logic                r_bad;

  assign w_xfer    = dout_vld && dout_rdy;
  assign dout_chan = r_chan;
  assign ovf       = r_ovf;
  assign bad_chan  = r_bad;

  genvar g;
  generate
    for (g = 0; g < CHAN_NUM; g++) begin : g_buf
      assign w_wr[g]   = din_vld && (din_chan == 2'(g));
      assign w_rd[g]   = (r_state == ST_DATA) && w_xfer && (r_chan == 2'(g));
      assign w_rdy[g]  = (w_count[g] >= CW'(FRAME_LEN));
      assign w_drop[g] = w_wr[g] && w_full[g] && !w_rd[g];

      chan_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
      ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .wr    (w_wr[g]),
        .wdata (din),
        .rd    (w_rd[g]),
        .rdata (w_rdata[g]),
        .count (w_count[g]),
        .full  (w_full[g])
      );
    end
  endgenerate

  // Head word of the channel currently being framed.
  always_comb begin
    w_head = w_rdata[0];
    case (r_chan)
      2'd1:    w_head = w_rdata[1];
      2'd2:    w_head = w_rdata[2];
      default: w_head = w_rdata[0];
    endcase
  end

  // Round-robin pick: nearest ready channel after the last one served.
  always_comb begin
    w_pick    = r_last;
    w_any_rdy = 1'b0;
    for (int k = CHAN_NUM; k >= 1; k--) begin
      if (w_rdy[rr_chan(r_last, k)]) begin
        w_pick    = rr_chan(r_last, k);
        w_any_rdy = 1'b1;
      end
    end
  end

  // Frame sequencer next state and output word selection.
  always_comb begin
    w_state_nxt = r_state;
    dout        = 16'h0000;
    dout_vld    = 1'b0;
    dout_sop    = 1'b0;
    dout_eop    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_rdy) begin
          w_state_nxt = ST_HEAD;
        end
      end
      ST_HEAD: begin
        dout     = build_hdr(HDR_TAG, r_chan);
        dout_vld = 1'b1;
        dout_sop = 1'b1;
        if (w_xfer) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        dout     = w_head;
        dout_vld = 1'b1;
        if (w_xfer && (r_beat == BW'(FRAME_LEN - 1))) begin
          w_state_nxt = ST_SUM;
        end
      end
      ST_SUM: begin
        dout     = r_sum;
        dout_vld = 1'b1;
        dout_eop = 1'b1;
        if (w_xfer) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus per-frame channel, beat count, checksum and arbiter history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_chan  <= 2'd0;
      r_last  <= 2'd2;
      r_beat  <= '0;
      r_sum   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_any_rdy) begin
            r_chan <= w_pick;
            r_sum  <= 16'h0000;
          end
        end
        ST_HEAD: begin
          if (w_xfer) begin
            r_beat <= '0;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_sum  <= r_sum + w_head;
            r_beat <= r_beat + BW'(1);
          end
        end
        ST_SUM: begin
          if (w_xfer) begin
            r_last <= r_chan;
          end
        end
        default: ;
      endcase
    end
  end

  // Overflow and illegal-channel pulses, one cycle after the offending input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_bad <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      r_bad <= din_vld && (din_chan == 2'd3);
    end
  end

endmodule

// File: tb/tb_chan_frame_pack.sv
// tb/tb_chan_frame_pack.sv - self-checking bench for chan_frame_pack against a queue model
module tb_chan_frame_pack;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_vld;
  logic [1:0]  din_chan;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        dout_sop;
  logic        dout_eop;
  logic [1:0]  dout_chan;
  logic [2:0]  ovf;
  logic        bad_chan;

  chan_frame_pack #(.FRAME_LEN(F), .HDR_TAG(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_chan  (din_chan),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .dout_chan (dout_chan),
    .ovf       (ovf),
    .bad_chan  (bad_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    bit          sop;
    bit          eop;
    bit          dat;
  } ow_t;

  ow_t         out_q[$];
  logic [15:0] chq[3][$];
  logic [15:0] got[$];
  int          m_last;
  int          m_cur;
  logic [2:0]  m_ovf;
  logic        m_bad;
  int          n_assert = 0;
  int          n_fail = 0;
  int          ovf0_cnt = 0;
  int          bad_cnt = 0;
  bit          chk_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic chk_list(input string tag, input logic [15:0] e[$]);
    chk({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 16'hxxxx, e[i]);
    end
  endtask

  function automatic bit any_ready();
    for (int c = 0; c < 3; c++) if (chq[c].size() >= F) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    out_q.delete();
    for (int c = 0; c < 3; c++) chq[c].delete();
    m_last = 2;
    m_cur  = 0;
    m_ovf  = '0;
    m_bad  = 1'b0;
  endtask

  // Behaviour of one clock edge: serve the output queue, accept input, arbitrate when idle.
  task automatic model_edge(input bit vld, input int chan, input logic [15:0] data, input bit rdy);
    bit          idle;
    int          sz[3];
    ow_t         o;
    logic [15:0] sum;
    idle = (out_q.size() == 0);
    for (int c = 0; c < 3; c++) sz[c] = chq[c].size();
    m_ovf = '0;
    m_bad = 1'b0;
    if (!idle && rdy) begin
      o = out_q.pop_front();
      if (o.dat) void'(chq[m_cur].pop_front());
      if (o.eop) m_last = m_cur;
    end
    if (vld) begin
      if (chan == 3) m_bad = 1'b1;
      else if (chq[chan].size() < 2 * F) chq[chan].push_back(data);
      else m_ovf[chan] = 1'b1;
    end
    if (idle) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (sz[c] >= F) begin
          m_cur = c;
          out_q.push_back('{w: 16'hA500 + 16'(c), sop: 1, eop: 0, dat: 0});
          sum = 16'h0000;
          for (int i = 0; i < F; i++) begin
            sum = sum + chq[c][i];
            out_q.push_back('{w: chq[c][i], sop: 0, eop: 0, dat: 1});
          end
          out_q.push_back('{w: sum, sop: 0, eop: 1, dat: 0});
          break;
        end
      end
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model, wait for next cycle.
  task automatic tick(input bit vld, input int chan, input logic [15:0] data, input bit rdy);
    din_vld  = vld;
    din_chan = 2'(chan);
    din      = data;
    dout_rdy = rdy;
    #1;
    if (chk_en) begin
      chk("dout_vld", dout_vld, out_q.size() > 0);
      if (out_q.size() > 0) begin
        chk("dout", dout, out_q[0].w);
        chk("dout_sop", dout_sop, out_q[0].sop);
        chk("dout_eop", dout_eop, out_q[0].eop);
      end
      chk("dout_chan", dout_chan, m_cur);
      chk("ovf", ovf, m_ovf);
      chk("bad_chan", bad_chan, m_bad);
    end
    if (dout_vld && dout_rdy) got.push_back(dout);
    if (ovf[0]) ovf0_cnt++;
    if (bad_chan) bad_cnt++;
    if (rst) model_reset();
    else model_edge(vld, chan, data, rdy);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() > 0 || any_ready()) && n < 300) begin
      tick(0, 0, 16'h0, 1);
      n++;
    end
    chk("drain_done", out_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 16'h0, 1);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] e[$];
    int n;
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    din_chan = '0;
    dout_rdy = 1'b1;
    @(negedge clk);
    do_reset();
    chk_en = 1;

    chk("rst_dout", dout, 16'h0000);
    chk("rst_vld", dout_vld, 1'b0);
    chk("rst_sop_eop", {dout_sop, dout_eop}, 2'b00);
    chk("rst_chan", dout_chan, 2'd0);
    chk("rst_flags", {ovf, bad_chan}, 4'h0);

    // Basic ch0 frame and header latency.
    got.delete();
    for (int i = 1; i <= 4; i++) tick(1, 0, 16'(i), 1);
    chk("lat_e1_vld", dout_vld, 1'b0);
    tick(0, 0, 16'h0, 1);
    chk("lat_e2_hdr", {dout_vld, dout_sop, dout}, {2'b11, 16'hA500});
    drain();
    e = {16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};
    chk_list("basic", e);

    // Two channels ready close together: ch1 first, then ch2 after a bubble.
    do_reset();
    got.delete();
    for (int i = 1; i <= 3; i++) tick(1, 1, 16'(i), 1);
    for (int i = 5; i <= 7; i++) tick(1, 2, 16'(i), 1);
    tick(1, 1, 16'h0004, 1);
    tick(1, 2, 16'h0008, 1);
    drain();
    e = {16'hA501, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A,
         16'hA502, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001A};
    chk_list("rr", e);

    // Back-pressure while on the second payload word.
    got.delete();
    for (int i = 0; i < 4; i++) tick(1, 0, 16'h0010 + 16'(i), 1);
    n = 0;
    while (!(out_q.size() == F && out_q[0].dat) && n < 50) begin
      tick(0, 0, 16'h0, 1);
      n++;
    end
    chk("stall_reach", out_q.size(), F);
    repeat (5) tick(0, 0, 16'h0, 0);
    drain();
    e = {16'hA500, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0046};
    chk_list("stall", e);

    // Overflow on ch0 with the sink stalled.
    do_reset();
    got.delete();
    ovf0_cnt = 0;
    for (int i = 1; i <= 9; i++) tick(1, 0, 16'(i), 0);
    repeat (3) tick(0, 0, 16'h0, 0);
    drain();
    chk("ovf0_pulses", ovf0_cnt, 1);
    e = {16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A,
         16'hA500, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001A};
    chk_list("ovf", e);

    // Checksum wrap on ch2 plus an illegal channel word mixed in.
    got.delete();
    bad_cnt = 0;
    tick(1, 2, 16'hFFFF, 1);
    tick(1, 2, 16'h0002, 1);
    tick(1, 3, 16'h1234, 1);
    tick(1, 2, 16'h0000, 1);
    tick(1, 2, 16'h0000, 1);
    drain();
    chk("bad_pulses", bad_cnt, 1);
    e = {16'hA502, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0001};
    chk_list("wrap", e);

    // Reset in the middle of the payload, then a fresh frame.
    for (int i = 1; i <= 4; i++) tick(1, 0, 16'(i), 1);
    n = 0;
    while (!(out_q.size() == F && out_q[0].dat) && n < 50) begin
      tick(0, 0, 16'h0, 1);
      n++;
    end
    chk("mid_reach", out_q.size(), F);
    do_reset();
    chk("mid_rst_vld", dout_vld, 1'b0);
    got.delete();
    for (int i = 5; i <= 8; i++) tick(1, 0, 16'(i), 1);
    drain();
    e = {16'hA500, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001A};
    chk_list("post_rst", e);

    // Random traffic against the model.
    repeat (600) begin
      tick($urandom_range(0, 99) < 60, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
           16'($urandom), $urandom_range(0, 99) < 70);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
